counter_ctrl: RTL and testbench

Sequencing controller for the 4-bit binary counter. It turns the two raw board buttons into the counter's single-cycle `enable` pulse. Three modes are supported: manual single-step, auto-run slow and auto-run fast, with pause/resume in the auto modes. It sits between the board push-buttons and the counter's `enable` input, on the same low-frequency clock and reset as the counter.

---
 rtl/counter_ctrl_pkg.sv | 20 ++
 rtl/counter_ctrl_button.sv | 63 ++++++
 rtl/counter_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: mode encoding,
// default timing parameters and a counter-width helper.
package counter_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MANUAL    = 2'd0;
    localparam mode_t MODE_AUTO_SLOW = 2'd1;
    localparam mode_t MODE_AUTO_FAST = 2'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SLOW_PERIOD     = 16;
    localparam int DEF_FAST_PERIOD     = 4;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_ctrl_button.sv
// Raw push-button conditioning: 2-FF synchronizer, consecutive-sample
// debounce counter and a one-cycle pulse on each debounced press (1->0).
module button_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic pressed_level,
    output logic press_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    logic w_mismatch;
    logic w_flip;

    assign w_mismatch = (r_sync2 != r_level);
    // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    assign w_flip     = w_mismatch && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Bring the asynchronous button into the clock domain (released = 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive mismatches; accept the new level and flag a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_flip && r_level;
            if (!w_mismatch || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_flip) begin
                r_level <= r_sync2;
            end
        end
    end

    assign pressed_level = ~r_level;
    assign press_pulse   = r_pulse;

endmodule

// File: rtl/counter_ctrl.sv
// Turns the step and mode buttons into the counter's single-cycle enable:
// manual single-step, auto-run slow and auto-run fast with pause/resume.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SLOW_PERIOD     = DEF_SLOW_PERIOD,
    parameter int FAST_PERIOD     = DEF_FAST_PERIOD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step_n,
    input  logic       btn_mode_n,
    output logic       enable,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int PW = cnt_width(SLOW_PERIOD);

    logic w_step_pulse;
    logic w_mode_pulse;
    logic w_step_level;
    logic w_mode_level;
    logic w_unused_levels;

    mode_t         r_mode;
    mode_t         w_mode_next;
    logic          r_paused;
    logic          w_paused_next;
    logic [PW-1:0] r_period_cnt;
    logic [PW-1:0] w_period_cnt_next;
    logic [PW-1:0] w_period_last;
    logic          r_enable;
    logic          w_enable_next;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_step_n),
        .pressed_level (w_step_level),
        .press_pulse   (w_step_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_mode_n),
        .pressed_level (w_mode_level),
        .press_pulse   (w_mode_pulse)
    );

    // Held levels are not needed by the sequencer; only press events are.
    assign w_unused_levels = w_step_level ^ w_mode_level;

    assign w_period_last = (r_mode == MODE_AUTO_FAST) ? PW'(FAST_PERIOD - 1)
                                                      : PW'(SLOW_PERIOD - 1);

    // Mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_MANUAL;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Mode next state: each mode press advances MANUAL -> SLOW -> FAST -> MANUAL.
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_pulse) begin
            case (r_mode)
                MODE_MANUAL:    w_mode_next = MODE_AUTO_SLOW;
                MODE_AUTO_SLOW: w_mode_next = MODE_AUTO_FAST;
                default:        w_mode_next = MODE_MANUAL;
            endcase
        end
    end

    // Pause flag, period counter and enable next values; a mode press wins
    // over a simultaneous step press, which is then dropped.
    always_comb begin
        w_paused_next     = r_paused;
        w_period_cnt_next = r_period_cnt;
        w_enable_next     = 1'b0;
        if (w_mode_pulse) begin
            w_paused_next     = 1'b0;
            w_period_cnt_next = '0;
        end else if (r_mode == MODE_MANUAL) begin
            w_paused_next     = 1'b0;
            w_period_cnt_next = '0;
            w_enable_next     = w_step_pulse;
        end else if (w_step_pulse) begin
            w_paused_next = ~r_paused;
        end else if (!r_paused) begin
            if (r_period_cnt == w_period_last) begin
                w_period_cnt_next = '0;
                w_enable_next     = 1'b1;
            end else begin
                w_period_cnt_next = r_period_cnt + PW'(1);
            end
        end
    end

    // Register pause flag, period counter and the enable pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paused     <= 1'b0;
            r_period_cnt <= '0;
            r_enable     <= 1'b0;
        end else begin
            r_paused     <= w_paused_next;
            r_period_cnt <= w_period_cnt_next;
            r_enable     <= w_enable_next;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        enable = r_enable;
        mode   = r_mode;
        paused = r_paused;
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus randomized button activity,
// every cycle compared against a behavioural model of the controller.
module tb_counter_ctrl;

    localparam int D    = 4;
    localparam int SLOW = 16;
    localparam int FAST = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_step_n;
    logic       btn_mode_n;
    logic       enable;
    logic [1:0] mode;
    logic       paused;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    counter_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .SLOW_PERIOD     (SLOW),
        .FAST_PERIOD     (FAST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step_n (btn_step_n),
        .btn_mode_n (btn_mode_n),
        .enable     (enable),
        .mode       (mode),
        .paused     (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // A button's accepted level changes at edge t when the raw samples taken
    // at edges t-D-1 .. t-2 all disagree with it (two edges of synchronizer
    // delay, then D stable samples). A press is such a change to 0; its
    // effect on the outputs is visible after the following edge.
    bit hs [0:D+1];
    bit hm [0:D+1];
    bit lvl_s, lvl_m, ev_s, ev_m;
    int m_mode, m_paused, m_en, m_run;

    function automatic bit accepted(input bit h [0:D+1], input bit lvl);
        for (int k = 2; k <= D + 1; k++) if (h[k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k <= D + 1; k++) begin hs[k] = 1'b1; hm[k] = 1'b1; end
        lvl_s = 1; lvl_m = 1; ev_s = 0; ev_m = 0;
        m_mode = 0; m_paused = 0; m_en = 0; m_run = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int period;
            bit fs, fm;
            period = (m_mode == 2) ? FAST : SLOW;
            m_en   = 0;
            if (ev_m) begin
                m_mode   = (m_mode + 1) % 3;
                m_paused = 0;
                m_run    = 0;
                $display("[%0t] mode press -> mode %0d", $time, m_mode);
            end else if (m_mode == 0) begin
                if (ev_s) begin
                    m_en = 1;
                    $display("[%0t] step press -> single step", $time);
                end
            end else if (ev_s) begin
                m_paused = !m_paused;
                $display("[%0t] step press -> paused %0d", $time, m_paused);
            end else if (!m_paused) begin
                m_run++;
                if (m_run % period == 0) m_en = 1;
            end
            for (int k = D + 1; k > 0; k--) begin hs[k] = hs[k-1]; hm[k] = hm[k-1]; end
            hs[0] = btn_step_n;
            hm[0] = btn_mode_n;
            fs = accepted(hs, lvl_s);
            fm = accepted(hm, lvl_m);
            ev_s = fs && lvl_s;
            ev_m = fm && lvl_m;
            if (fs) lvl_s = !lvl_s;
            if (fm) lvl_m = !lvl_m;
        end
    end

    // Every cycle, compare all outputs on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("enable", int'(enable), m_en);
            check("mode",   int'(mode),   m_mode);
            check("paused", int'(paused), m_paused);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit is_mode, input int hold, input int rel);
        if (is_mode) btn_mode_n = 1'b0; else btn_step_n = 1'b0;
        idle(hold);
        if (is_mode) btn_mode_n = 1'b1; else btn_step_n = 1'b1;
        idle(rel);
    endtask

    initial begin
        btn_step_n = 1'b1;
        btn_mode_n = 1'b1;
        rst_n      = 1'b0;
        model_reset();
        idle(2);
        chk_en = 1;

        // Reset held while the buttons bounce around: outputs stay at reset values.
        for (int i = 0; i < 12; i++) begin
            btn_step_n = 1'($urandom_range(0, 1));
            btn_mode_n = 1'($urandom_range(0, 1));
            idle(1);
        end
        btn_step_n = 1'b1;
        btn_mode_n = 1'b1;
        idle(1);
        @(negedge clk); #3 rst_n = 1'b1;
        idle(10);

        // Manual step latency: low first sampled at edge N, enable after edge N+D+2.
        @(posedge clk); #2 btn_step_n = 1'b0;
        @(posedge clk);                       // edge N
        repeat (D + 1) @(posedge clk);        // edge N+D+1
        @(negedge clk) check("step_latency_early", int'(enable), 0);
        @(posedge clk);                       // edge N+D+2
        @(negedge clk) check("step_latency", int'(enable), 1);
        @(negedge clk) check("step_single", int'(enable), 0);
        idle(14);
        btn_step_n = 1'b1;
        idle(12);

        // Short glitches are rejected.
        for (int g = 1; g < D; g++) press(0, g, 10);
        press(1, $urandom_range(1, D - 1), 10);

        // Mode cycling: four presses -> 1, 2, 0, 1.
        for (int i = 0; i < 4; i++) press(1, 10, 8);
        // Back through FAST to MANUAL, then into AUTO_SLOW and let it run.
        press(1, 8, 6);
        press(1, 8, 6);
        press(1, 8, 70);
        // AUTO_FAST run, pause, hold paused, resume.
        press(1, 8, 20);
        press(0, 8, 30);
        press(0, 8, 24);
        // Back to MANUAL, then simultaneous step + mode press.
        press(1, 8, 10);
        btn_step_n = 1'b0;
        btn_mode_n = 1'b0;
        idle(10);
        btn_step_n = 1'b1;
        btn_mode_n = 1'b1;
        idle(12);
        check("collision_mode", int'(mode), 1);

        // Pause in AUTO_SLOW, then assert reset mid-cycle.
        press(0, 8, 12);
        check("paused_before_reset", int'(paused), 1);
        @(negedge clk); #3 rst_n = 1'b0;
        #1;
        check("async_rst_mode",   int'(mode),   0);
        check("async_rst_paused", int'(paused), 0);
        check("async_rst_enable", int'(enable), 0);
        // Step button held through reset release: a fresh press afterwards.
        btn_step_n = 1'b0;
        idle(3);
        @(negedge clk); #3 rst_n = 1'b1;
        idle(12);
        btn_step_n = 1'b1;
        idle(10);

        // Randomized button activity with occasional resets.
        for (int s = 0; s < 600; s++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                @(negedge clk); #3 rst_n = 1'b0;
                idle(int'($urandom_range(1, 3)));
                @(negedge clk); #3 rst_n = 1'b1;
            end else begin
                btn_step_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                btn_mode_n = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                idle(int'($urandom_range(1, 12)));
            end
        end
        btn_step_n = 1'b1;
        btn_mode_n = 1'b1;
        idle(20);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
